// File: rtl/mic1_uart_rx_io.sv
// mic1 memory-mapped serial receiver: 8N1 deserializer feeding a byte FIFO,
// read through the data port (IO_ADDR pops a byte, STAT_ADDR returns sticky flags).
module mic1_uart_rx_io #(
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] IO_ADDR    = 32'hFFFFFFFD,
  parameter logic [31:0] STAT_ADDR  = 32'hFFFFFFFC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  input  logic        mem_read,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        io_hit,
  output logic        rx_avail
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_FULL = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  // Handshake: the receiver raises push_req for exactly one cycle with the byte
  // in shreg; the FIFO accepts it unless full with no simultaneous pop.

  logic            rx_s1, rx_s2;
  rx_state_t       state, state_d;
  logic [DW-1:0]   div, div_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [7:0]      shreg, shreg_d;
  logic            brk_wait, brk_wait_d;
  logic            push_req, ferr_set, ovf_set;
  logic            div_zero;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            fifo_empty, fifo_full;
  logic            io_rd, stat_rd, pop, push_ok;
  logic            ferr, ovf;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= ser_rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      div      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      brk_wait <= 1'b0;
    end else begin
      state    <= state_d;
      div      <= div_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      brk_wait <= brk_wait_d;
    end
  end

  assign div_zero = (div == '0);

  always_comb begin
    state_d    = state;
    div_d      = div;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    brk_wait_d = brk_wait;
    push_req   = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s2) begin
          div_d   = DIV_HALF;
          state_d = START;
        end
      end
      START: begin
        // Mid-bit re-check rejects short low glitches on an idle line.
        if (div_zero) begin
          if (!rx_s2) begin
            div_d     = DIV_FULL;
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_d = div - DIV_ONE;
        end
      end
      DATA: begin
        if (div_zero) begin
          shreg_d   = {rx_s2, shreg[7:1]};
          div_d     = DIV_FULL;
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end else begin
          div_d = div - DIV_ONE;
        end
      end
      STOP: begin
        // After a framing error, hold here until the line goes back to idle.
        if (brk_wait) begin
          if (rx_s2) begin
            brk_wait_d = 1'b0;
            state_d    = IDLE;
          end
        end else if (div_zero) begin
          if (rx_s2) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_set   = 1'b1;
            brk_wait_d = 1'b1;
          end
        end else begin
          div_d = div - DIV_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign io_rd      = mem_read && (mem_addr == IO_ADDR);
  assign stat_rd    = mem_read && (mem_addr == STAT_ADDR);
  assign pop        = io_rd && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && fifo_full && !pop;
  assign rx_avail   = !fifo_empty;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ferr      <= 1'b0;
      ovf       <= 1'b0;
      mem_rdata <= '0;
      io_hit    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      // A new event in the same cycle as a status read survives the clear.
      ferr   <= ferr_set | (ferr & ~stat_rd);
      ovf    <= ovf_set  | (ovf  & ~stat_rd);
      io_hit <= io_rd | stat_rd;
      if (io_rd) begin
        mem_rdata <= fifo_empty ? 32'h0 : {24'h0, fifo_mem[rd_ptr[AW-1:0]]};
      end else if (stat_rd) begin
        mem_rdata <= {29'h0, ovf, ferr, !fifo_empty};
      end
    end
  end

endmodule

// File: tb/tb_mic1_uart_rx_io.sv
// Randomized bench for mic1_uart_rx_io: serial frames and data-port reads
// checked against a byte-queue model of the receiver and its status flags.
module tb_mic1_uart_rx_io;

  localparam int          CLK_DIV    = 8;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] IO_ADDR    = 32'hFFFFFFFD;
  localparam logic [31:0] STAT_ADDR  = 32'hFFFFFFFC;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ser_rx = 1'b1;
  logic        mem_read = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_rdata;
  logic        io_hit;
  logic        rx_avail;

  mic1_uart_rx_io #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH),
    .IO_ADDR(IO_ADDR), .STAT_ADDR(STAT_ADDR)
  ) dut (
    .clk(clk), .resetn(resetn), .ser_rx(ser_rx),
    .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .io_hit(io_hit), .rx_avail(rx_avail)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  bit          m_ferr = 1'b0;
  bit          m_ovf  = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ferr  = 1'b0;
    m_ovf   = 1'b0;
    m_rdata = 32'h0;
  endtask

  // driver tasks: all start and end on a falling clock edge
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    ser_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    ser_rx = stop_ok;
    repeat (CLK_DIV) @(negedge clk);
    ser_rx = 1'b1;
    repeat (6) @(negedge clk);
    model_frame(b, stop_ok);
  endtask

  task automatic do_read(input logic [31:0] addr, input string tag);
    logic [31:0] exp_d;
    logic        exp_h;
    if (addr == IO_ADDR) begin
      exp_h = 1'b1;
      exp_d = 32'h0;
      if (exp_q.size() > 0) exp_d = {24'h0, exp_q.pop_front()};
    end else if (addr == STAT_ADDR) begin
      exp_h = 1'b1;
      exp_d = {29'h0, m_ovf, m_ferr, (exp_q.size() != 0)};
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      exp_h = 1'b0;
      exp_d = m_rdata;
    end
    m_rdata  = exp_d;
    mem_read = 1'b1;
    mem_addr = addr;
    @(negedge clk);
    mem_read = 1'b0;
    mem_addr = $urandom;
    check({tag, "_data"}, mem_rdata, exp_d);
    check({tag, "_hit"}, {31'h0, io_hit}, {31'h0, exp_h});
  endtask

  task automatic glitch();
    ser_rx = 1'b0;
    @(negedge clk);
    ser_rx = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_avail(input string tag);
    check(tag, {31'h0, rx_avail}, {31'h0, (exp_q.size() != 0)});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) do_read(IO_ADDR, tag);
    check_avail({tag, "_avail"});
  endtask

  initial begin
    int lat;
    logic [7:0] b;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_hit", {31'h0, io_hit}, 32'h0);
    check("rst_avail", {31'h0, rx_avail}, 32'h0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // first frame with push latency measured from the start-bit edge
    lat = 0;
    fork
      send_frame(8'h33, 1'b1);
      begin
        int c = 0;
        while (!rx_avail && c < 200) begin
          @(negedge clk);
          c++;
        end
        lat = c;
      end
    join
    check("push_latency_in_range", {31'h0, (lat >= 9 * CLK_DIV + CLK_DIV / 2 + 2 &&
                                            lat <= 9 * CLK_DIV + CLK_DIV / 2 + 4)}, 32'h1);
    do_read(IO_ADDR, "rd_33");
    send_frame(8'h0A, 1'b1);
    do_read(IO_ADDR, "rd_0a");
    check_avail("avail_after_two");

    // empty FIFO reads
    do_read(IO_ADDR, "rd_empty");
    do_read(STAT_ADDR, "stat_empty");

    // overflow: five bytes into a four-entry FIFO
    for (int i = 0; i < 5; i++) send_frame(8'h41 + 8'(i), 1'b1);
    drain("ovf_drain");
    do_read(STAT_ADDR, "stat_ovf");
    do_read(STAT_ADDR, "stat_ovf_clr");

    // framing error, then recovery
    send_frame(8'h55, 1'b0);
    check_avail("ferr_avail");
    do_read(STAT_ADDR, "stat_ferr");
    send_frame(8'h36, 1'b1);
    do_read(IO_ADDR, "rd_36");

    // short glitch on an idle line
    glitch();
    check_avail("glitch_avail");
    do_read(STAT_ADDR, "stat_glitch");

    // push coinciding with a pop while full: accepted, no overflow
    for (int i = 0; i < FIFO_DEPTH; i++) send_frame(8'($urandom), 1'b1);
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1);
      begin
        repeat (9 * CLK_DIV + CLK_DIV / 2 + 2) @(negedge clk);
        do_read(IO_ADDR, "pp_full");
      end
    join
    do_read(STAT_ADDR, "stat_pp_full");
    drain("pp_full_drain");

    // push coinciding with a read of an empty FIFO: read gets 0, byte kept
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1);
      begin
        repeat (9 * CLK_DIV + CLK_DIV / 2 + 2) @(negedge clk);
        do_read(IO_ADDR, "pp_empty");
      end
    join
    check_avail("pp_empty_avail");
    do_read(IO_ADDR, "pp_empty_kept");

    // reset during data bit 4 with two bytes queued
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    b = 8'hC9;
    ser_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ser_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    ser_rx = b[4];
    repeat (CLK_DIV / 2) @(negedge clk);
    resetn = 1'b0;
    ser_rx = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_avail", {31'h0, rx_avail}, 32'h0);
    check("midrst_rdata", mem_rdata, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    do_read(STAT_ADDR, "midrst_stat");
    do_read(IO_ADDR, "midrst_io");
    send_frame(8'h35, 1'b1);
    do_read(IO_ADDR, "rd_35");

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: send_frame(8'($urandom), ($urandom_range(0, 5) != 0));
        3:       do_read(IO_ADDR, "rnd_io");
        4:       do_read(STAT_ADDR, "rnd_stat");
        5:       do_read($urandom & 32'h7FFFFFFF, "rnd_other");
        default: glitch();
      endcase
      check_avail("rnd_avail");
    end
    drain("final_drain");
    do_read(STAT_ADDR, "final_stat");

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
